// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_EXC  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_npc.sv
// Next-PC selection: flush target (live or pending) beats pending branch beats pc+4.
module fetch_npc (
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fl_pend_i,
  input  logic [31:0] fl_tgt_i,
  input  logic        br_pend_i,
  input  logic [31:0] br_tgt_i,
  input  logic [31:0] pc_i,
  output logic [31:0] npc_o,
  output logic        misaligned_o
);

  always_comb begin
    npc_o = pc_i + 32'd4;
    if (flush_i)        npc_o = flush_pc_i;
    else if (fl_pend_i) npc_o = fl_tgt_i;
    else if (br_pend_i) npc_o = br_tgt_i;
  end

  assign misaligned_o = |npc_o[1:0];

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, sequences one address request per slot and
// applies branch/flush redirects; misaligned PCs become AdEL slots with no request.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        ready_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic        cancelled_o,
  output logic        exc_o,
  output logic        exc_miss_o,
  output logic [4:0]  exccode_o,
  output logic [31:0] perfcnt_fetch_stall,
  output logic [1:0]  state_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         valid_q;
  logic         cancelled_q;
  logic         exc_q;
  logic [4:0]   exccode_q;
  logic         br_pend_q;
  logic [31:0]  br_tgt_q;
  logic         fl_pend_q;
  logic [31:0]  fl_tgt_q;
  logic [31:0]  stall_q;

  logic [31:0]  npc;
  logic         npc_misaligned;
  logic         advance;

  // A slot departs only from WAIT or EXC when decode consumes it.
  assign advance = ((state_q == ST_WAIT) || (state_q == ST_EXC)) && ready_i;

  fetch_npc u_npc (
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .fl_pend_i    (fl_pend_q),
    .fl_tgt_i     (fl_tgt_q),
    .br_pend_i    (br_pend_q),
    .br_tgt_i     (br_tgt_q),
    .pc_i         (pc_q),
    .npc_o        (npc),
    .misaligned_o (npc_misaligned)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      cancelled_q <= 1'b0;
      exc_q       <= 1'b0;
      exccode_q   <= 5'h00;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= 32'h0;
      fl_pend_q   <= 1'b0;
      fl_tgt_q    <= 32'h0;
      stall_q     <= 32'h0;
    end else begin
      if ((state_q == ST_REQ) && !inst_addr_ok) stall_q <= stall_q + 32'd1;

      // Flush overrides any branch resolved in the same cycle; a flush that
      // coincides with a departure is consumed immediately by the next-PC mux.
      if (flush_i) begin
        br_pend_q <= 1'b0;
        fl_pend_q <= !advance;
        fl_tgt_q  <= flush_pc_i;
      end else begin
        if (advance) begin
          fl_pend_q <= 1'b0;
          br_pend_q <= 1'b0;
        end
        if (br_valid_i) begin
          br_pend_q <= 1'b1;
          br_tgt_q  <= br_target_i;
        end
      end

      case (state_q)
        ST_IDLE: begin
          state_q   <= (|pc_q[1:0]) ? ST_EXC : ST_REQ;
          valid_q   <= |pc_q[1:0];
          exc_q     <= |pc_q[1:0];
          exccode_q <= (|pc_q[1:0]) ? EXC_ADEL : 5'h00;
        end
        ST_REQ: begin
          if (inst_addr_ok) begin
            state_q <= ST_WAIT;
            valid_q <= 1'b1;
          end
          if (flush_i) cancelled_q <= 1'b1;
        end
        default: begin
          if (ready_i) begin
            pc_q        <= npc;
            state_q     <= npc_misaligned ? ST_EXC : ST_REQ;
            valid_q     <= npc_misaligned;
            exc_q       <= npc_misaligned;
            exccode_q   <= npc_misaligned ? EXC_ADEL : 5'h00;
            cancelled_q <= 1'b0;
          end else if (flush_i) begin
            cancelled_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign inst_req            = (state_q == ST_REQ);
  assign inst_addr           = pc_q;
  assign pc_o                = pc_q;
  assign valid_o             = valid_q;
  assign cancelled_o         = cancelled_q;
  assign exc_o               = exc_q;
  assign exc_miss_o          = 1'b0;
  assign exccode_o           = exccode_q;
  assign perfcnt_fetch_stall = stall_q;
  assign state_o             = state_q;

endmodule
